// File: rtl/conv1d_reg_slave.sv
// conv1d_reg_slave: parametrised register-bus slave and register file for the conv1d accelerator.
// Latency: resp_ready_o pulses WAIT_CYCLES+1 cycles after a request is accepted in IDLE.
// Backpressure: one outstanding request; new requests are accepted only in IDLE, the cycle after RESP at the earliest.
module conv1d_reg_slave #(
  parameter int                            ADDR_W      = 32,
  parameter int                            DATA_W      = 32,
  parameter int                            NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0]             BASE_ADDR   = '0,
  parameter int                            WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]           RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]           W1P_MASK    = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]    RST_VAL     = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  input  logic                             req_write_i,
  input  logic [DATA_W/8-1:0]              req_wstrb_i,
  input  logic [ADDR_W-1:0]                req_addr_i,
  input  logic [DATA_W-1:0]                req_wdata_i,
  output logic                             resp_ready_o,
  output logic                             resp_error_o,
  output logic [DATA_W-1:0]                resp_rdata_o,
  output logic [NUM_REGS*DATA_W-1:0]       reg_q_o,
  input  logic [NUM_REGS-1:0]              hw_we_i,
  input  logic [NUM_REGS*DATA_W-1:0]       hw_d_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [ADDR_W-1:0]   offset;
  logic [ADDR_W-1:0]   word;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_err;
  logic                accept;
  logic                commit;
  logic [DATA_W-1:0]   strb_mask;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  // Address decode of the live request; only used on the accepting cycle
  always_comb begin
    offset  = req_addr_i - BASE_ADDR;
    word    = offset >> LSB;
    dec_idx = word[IDX_W-1:0];
    dec_err = (req_addr_i < BASE_ADDR) || (|offset[LSB-1:0]) || (word >= ADDR_W'(NUM_REGS));
    if (!dec_err && req_write_i && RO_MASK[dec_idx]) begin
      dec_err = 1'b1;
    end
  end

  assign accept = (state_q == S_IDLE) && req_valid_i;

  // State register and wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Capture the request and its decode result when it is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write_i;
      err_q   <= dec_err;
      idx_q   <= dec_idx;
      wstrb_q <= req_wstrb_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Response outputs; read data reflects register contents during the RESP cycle
  always_comb begin
    resp_ready_o = (state_q == S_RESP) && !rst_i;
    resp_error_o = resp_ready_o && err_q;
    resp_rdata_o = '0;
    if (resp_ready_o && !err_q && !wr_q && !W1P_MASK[idx_q]) begin
      resp_rdata_o = regs_flat[idx_q*DATA_W +: DATA_W];
    end
  end

  // Expand byte strobes into a bit mask for the committing write
  always_comb begin
    strb_mask = '0;
    for (int k = 0; k < STRB_W; k++) begin
      strb_mask[k*8 +: 8] = {8{wstrb_q[k]}};
    end
  end

  // A bus write commits on the edge that ends RESP; errored writes never commit
  assign commit = (state_q == S_RESP) && wr_q && !err_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] q, d;
    logic              hit;

    assign hit = commit && (idx_q == IDX_W'(i));

    if (W1P_MASK[i]) begin : g_w1p
      // Pulse register: holds written bits for one cycle, ignores the hardware path
      always_comb begin
        d = hit ? (wdata_q & strb_mask) : '0;
      end
    end else begin : g_rw
      // Hardware load first, then strobed bus bytes override it
      always_comb begin
        d = hw_we_i[i] ? hw_d_i[i*DATA_W +: DATA_W] : q;
        if (hit) begin
          d = (d & ~strb_mask) | (wdata_q & strb_mask);
        end
      end
    end

    // Register storage; pulse registers always reset to zero
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        q <= W1P_MASK[i] ? '0 : RST_VAL[i*DATA_W +: DATA_W];
      end else begin
        q <= d;
      end
    end

    assign regs_flat[i*DATA_W +: DATA_W] = q;
  end

  assign reg_q_o = regs_flat;

endmodule

// File: tb/tb_conv1d_reg_slave.sv
// Bench for conv1d_reg_slave: two instances (0 and 3 wait states) sharing one register map.
// Directed scenarios from the register-map rules plus randomized traffic against an array model.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_conv1d_reg_slave;
  localparam int NR = 16;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [NR-1:0] RO  = 16'h0028;
  localparam logic [NR-1:0] W1P = 16'h0001;
  localparam logic [NR*DW-1:0] RV = (512'h5A)
                                  | (512'hA5 << 64)
                                  | (512'h12345678 << 96)
                                  | (512'hCAFE0005 << 160);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       req_valid, req_write, resp_ready, resp_error;
  logic [3:0]       req_wstrb [2];
  logic [AW-1:0]    req_addr  [2];
  logic [DW-1:0]    req_wdata [2];
  logic [DW-1:0]    resp_rdata[2];
  logic [NR*DW-1:0] regq [2];
  logic [NR*DW-1:0] hw_d [2];
  logic [NR-1:0]    hw_we[2];

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [2][NR];

  conv1d_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR('0), .WAIT_CYCLES(0),
                     .RO_MASK(RO), .W1P_MASK(W1P), .RST_VAL(RV)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_write_i(req_write[0]),
    .req_wstrb_i(req_wstrb[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_ready_o(resp_ready[0]), .resp_error_o(resp_error[0]), .resp_rdata_o(resp_rdata[0]),
    .reg_q_o(regq[0]), .hw_we_i(hw_we[0]), .hw_d_i(hw_d[0]));

  conv1d_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR('0), .WAIT_CYCLES(3),
                     .RO_MASK(RO), .W1P_MASK(W1P), .RST_VAL(RV)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_write_i(req_write[1]),
    .req_wstrb_i(req_wstrb[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_ready_o(resp_ready[1]), .resp_error_o(resp_error[1]), .resp_rdata_o(resp_rdata[1]),
    .reg_q_o(regq[1]), .hw_we_i(hw_we[1]), .hw_d_i(hw_d[1]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reset image as seen by the datapath (pulse register 0 always comes up as zero)
  function automatic logic [31:0] rst_val(input int r);
    case (r)
      2: return 32'h0000_00A5;
      3: return 32'h1234_5678;
      5: return 32'hCAFE_0005;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[k*8 +: 8] = {8{s[k]}};
    return m;
  endfunction

  function automatic logic exp_err(input logic wr, input logic [31:0] addr);
    int idx;
    idx = int'(addr / 4);
    if (addr % 4 != 0) return 1'b1;
    if (idx >= NR) return 1'b1;
    return wr && RO[idx];
  endfunction

  function automatic logic [NR*DW-1:0] exp_vec(input int d, input logic [31:0] pulse);
    logic [NR*DW-1:0] v;
    for (int r = 0; r < NR; r++) v[r*32 +: 32] = (r == 0) ? pulse : mdl[d][r];
    return v;
  endfunction

  task automatic model_reset(input int d);
    for (int r = 0; r < NR; r++) mdl[d][r] = rst_val(r);
  endtask

  // Apply one bus transaction (plus optional same-cycle hardware load) to the model
  task automatic model_commit(input int d, input logic wr, input logic [3:0] strb,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int hw_idx, input logic [31:0] hw_val,
                              output logic [31:0] pulse);
    int idx;
    pulse = 32'h0;
    if (hw_idx >= 0 && !W1P[hw_idx]) mdl[d][hw_idx] = hw_val;
    if (wr && !exp_err(wr, addr)) begin
      idx = int'(addr / 4);
      if (W1P[idx]) pulse = wdata & bmask(strb);
      else mdl[d][idx] = (mdl[d][idx] & ~bmask(strb)) | (wdata & bmask(strb));
    end
  endtask

  // Drive one request, wait (bounded) for the response, observe the cycle after it
  task automatic bus_txn(input int d, input logic wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int hw_idx, input logic [31:0] hw_val,
                         output int lat, output logic err, output logic [31:0] rdata,
                         output logic rdy_after, output logic [NR*DW-1:0] post_q);
    logic rdy;
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_write[d] = wr; req_wstrb[d] = strb;
    req_addr[d] = addr;  req_wdata[d] = wdata;
    lat = 0; rdy = 1'b0;
    while (!rdy && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      rdy = resp_ready[d];
    end
    if (!rdy) lat = -1;
    err = resp_error[d];
    rdata = resp_rdata[d];
    req_valid[d] = 1'b0;
    if (hw_idx >= 0) begin
      hw_we[d][hw_idx] = 1'b1;
      hw_d[d][hw_idx*32 +: 32] = hw_val;
    end
    @(posedge clk); #1;
    hw_we[d] = '0;
    rdy_after = resp_ready[d];
    post_q = regq[d];
  endtask

  task automatic hw_poke(input int d, input int idx, input logic [31:0] val);
    @(posedge clk); #1;
    hw_we[d][idx] = 1'b1;
    hw_d[d][idx*32 +: 32] = val;
    @(posedge clk); #1;
    hw_we[d] = '0;
    if (!W1P[idx]) mdl[d][idx] = val;
  endtask

  task automatic test_reset();
    rst = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      checks++; if (resp_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 0", d, resp_ready[d]); end
      checks++; if (resp_error[d] !== 1'b0) begin errors++; $display("FAIL reset_error[%0d]: got %b want 0", d, resp_error[d]); end
      checks++; if (resp_rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, resp_rdata[d]); end
      checks++; if (regq[d] !== exp_vec(d, 32'h0)) begin errors++; $display("FAIL reset_regs[%0d]: got %h want %h", d, regq[d], exp_vec(d, 32'h0)); end
    end
    @(posedge clk); #1;
    rst = 2'b00;
  endtask

  task automatic test_reset_value();
    int lat; logic err, ra; logic [31:0] rd; logic [NR*DW-1:0] pq;
    bus_txn(0, 1'b0, 4'h0, 32'h08, 32'h0, -1, 32'h0, lat, err, rd, ra, pq);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rstval_latency: got %0d want 1", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstval_error: got %b want 0", err); end
    checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL rstval_rdata: got %h want 000000a5", rd); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rstval_single_cycle: ready still %b", ra); end
  endtask

  task automatic test_byte_strobe();
    int lat; logic err, ra; logic [31:0] rd, pl; logic [NR*DW-1:0] pq;
    for (int d = 0; d < 2; d++) begin
      bus_txn(d, 1'b1, 4'b0101, 32'h04, 32'hDEADBEEF, -1, 32'h0, lat, err, rd, ra, pq);
      model_commit(d, 1'b1, 4'b0101, 32'h04, 32'hDEADBEEF, -1, 32'h0, pl);
      checks++; if (lat !== wait_of(d) + 1) begin errors++; $display("FAIL strobe_wr_latency[%0d]: got %0d want %0d", d, lat, wait_of(d) + 1); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL strobe_wr_error[%0d]: got %b want 0", d, err); end
      bus_txn(d, 1'b0, 4'h0, 32'h04, 32'h0, -1, 32'h0, lat, err, rd, ra, pq);
      checks++; if (lat !== wait_of(d) + 1) begin errors++; $display("FAIL strobe_rd_latency[%0d]: got %0d want %0d", d, lat, wait_of(d) + 1); end
      checks++; if (rd !== 32'h00AD00EF) begin errors++; $display("FAIL strobe_rdata[%0d]: got %h want 00ad00ef", d, rd); end
    end
  endtask

  task automatic test_errors();
    int lat; logic err, ra; logic [31:0] rd, pl; logic [NR*DW-1:0] pq;
    bus_txn(0, 1'b0, 4'h0, 32'h06, 32'h0, -1, 32'h0, lat, err, rd, ra, pq);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_error: got %b want 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h want 0", rd); end
    bus_txn(0, 1'b0, 4'h0, 32'h40, 32'h0, -1, 32'h0, lat, err, rd, ra, pq);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_error: got %b want 1", err); end
    bus_txn(0, 1'b1, 4'hF, 32'h0C, 32'h1, -1, 32'h0, lat, err, rd, ra, pq);
    model_commit(0, 1'b1, 4'hF, 32'h0C, 32'h1, -1, 32'h0, pl);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ro_write_error: got %b want 1", err); end
    checks++; if (pq[3*32 +: 32] !== 32'h1234_5678) begin errors++; $display("FAIL ro_unchanged: got %h want 12345678", pq[3*32 +: 32]); end
  endtask

  task automatic test_w1p();
    int lat; logic err, ra; logic [31:0] rd, pl; logic [NR*DW-1:0] pq;
    bus_txn(0, 1'b1, 4'hF, 32'h00, 32'h1, -1, 32'h0, lat, err, rd, ra, pq);
    model_commit(0, 1'b1, 4'hF, 32'h00, 32'h1, -1, 32'h0, pl);
    checks++; if (pq[31:0] !== 32'h1) begin errors++; $display("FAIL w1p_pulse: got %h want 1", pq[31:0]); end
    @(posedge clk); #1;
    checks++; if (regq[0][31:0] !== 32'h0) begin errors++; $display("FAIL w1p_clear: got %h want 0", regq[0][31:0]); end
    bus_txn(0, 1'b0, 4'h0, 32'h00, 32'h0, -1, 32'h0, lat, err, rd, ra, pq);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1p_read: got %h want 0", rd); end
  endtask

  task automatic test_collision();
    int lat; logic err, ra; logic [31:0] rd, pl; logic [NR*DW-1:0] pq;
    for (int d = 0; d < 2; d++) begin
      bus_txn(d, 1'b1, 4'b0011, 32'h10, 32'hAABBCCDD, 4, 32'h11223344, lat, err, rd, ra, pq);
      model_commit(d, 1'b1, 4'b0011, 32'h10, 32'hAABBCCDD, 4, 32'h11223344, pl);
      checks++; if (pq[4*32 +: 32] !== 32'h1122CCDD) begin errors++; $display("FAIL collision_rw[%0d]: got %h want 1122ccdd", d, pq[4*32 +: 32]); end
    end
    // Read-only register: hardware value lands even though the bus write errors
    bus_txn(0, 1'b1, 4'hF, 32'h14, 32'hFFFF0000, 5, 32'h0BADF00D, lat, err, rd, ra, pq);
    model_commit(0, 1'b1, 4'hF, 32'h14, 32'hFFFF0000, 5, 32'h0BADF00D, pl);
    checks++; if (pq[5*32 +: 32] !== 32'h0BADF00D) begin errors++; $display("FAIL collision_ro: got %h want 0badf00d", pq[5*32 +: 32]); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL collision_ro_error: got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    int lat; logic err, ra, seen; logic [31:0] rd; logic [NR*DW-1:0] pq;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_wstrb[1] = 4'hF;
    req_addr[1] = 32'h04; req_wdata[1] = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    rst[1] = 1'b1; req_valid[1] = 1'b0;
    seen = resp_ready[1];
    @(posedge clk); #1;
    seen = seen | resp_ready[1];
    rst[1] = 1'b0;
    model_reset(1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      seen = seen | resp_ready[1];
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_resp: ready seen %b want 0", seen); end
    checks++; if (regq[1] !== exp_vec(1, 32'h0)) begin errors++; $display("FAIL midrst_regs: got %h want %h", regq[1], exp_vec(1, 32'h0)); end
    bus_txn(1, 1'b0, 4'h0, 32'h08, 32'h0, -1, 32'h0, lat, err, rd, ra, pq);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_next_latency: got %0d want 4", lat); end
    checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL midrst_next_rdata: got %h want 000000a5", rd); end
  endtask

  task automatic test_random();
    int lat, hw_idx; logic err, ra, wr, xe; logic [3:0] strb;
    logic [31:0] addr, wdata, rd, hw_val, xr, pl; logic [NR*DW-1:0] pq;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 4) == 0) hw_poke(d, $urandom_range(0, NR - 1), $urandom);
        addr = 32'($urandom_range(0, 17) * 4);
        if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
        wr = 1'($urandom_range(0, 1));
        strb = 4'($urandom_range(0, 15));
        wdata = $urandom;
        hw_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : -1;
        hw_val = $urandom;
        xe = exp_err(wr, addr);
        xr = (!xe && !wr) ? mdl[d][int'(addr / 4)] : 32'h0;
        bus_txn(d, wr, strb, addr, wdata, hw_idx, hw_val, lat, err, rd, ra, pq);
        model_commit(d, wr, strb, addr, wdata, hw_idx, hw_val, pl);
        checks++; if (lat !== wait_of(d) + 1) begin errors++; $display("FAIL rnd_latency[%0d.%0d]: got %0d want %0d", d, n, lat, wait_of(d) + 1); end
        checks++; if (err !== xe) begin errors++; $display("FAIL rnd_error[%0d.%0d] addr %h wr %b: got %b want %b", d, n, addr, wr, err, xe); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rnd_single_cycle[%0d.%0d]: ready %b want 0", d, n, ra); end
        if (!wr || xe) begin
          checks++; if (rd !== xr) begin errors++; $display("FAIL rnd_rdata[%0d.%0d] addr %h: got %h want %h", d, n, addr, rd, xr); end
        end
        checks++; if (pq !== exp_vec(d, pl)) begin errors++; $display("FAIL rnd_regs[%0d.%0d]: got %h want %h", d, n, pq, exp_vec(d, pl)); end
      end
    end
  endtask

  initial begin
    rst = 2'b11;
    req_valid = '0; req_write = '0;
    for (int d = 0; d < 2; d++) begin
      req_wstrb[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
      hw_we[d] = '0; hw_d[d] = '0;
    end
    test_reset();
    test_reset_value();
    test_byte_strobe();
    test_errors();
    test_w1p();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
